// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the colour type exchanged with the renderers.
package vga_pkg;
  localparam int CNT_W    = 10;
  localparam int COLOR_W  = 4;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb12_t;
endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register advanced on i_en; async clear puts every stage to zero.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-enable divider, h/v counters, sync compares, and the
// output stage that re-times renderer colour against delayed sync and blanks it.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int PIPE_DLY = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       video_on,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);
  import vga_pkg::*;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_hcnt, r_vcnt, r_col, r_row;
  logic             r_video, r_hs, r_vs, r_frame_start;
  logic             r_hs_out, r_vs_out;
  rgb12_t           r_rgb;

  logic             w_pix_en, w_h_wrap, w_v_wrap;
  logic             w_active, w_hs, w_vs;
  logic [2:0]       w_dly;

  assign w_pix_en = (r_div == DIV_LAST);
  assign w_h_wrap = (r_hcnt == H_LAST);
  assign w_v_wrap = (r_vcnt == V_LAST);
  assign w_active = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
  assign w_hs     = (r_hcnt >= HS_BEG_C) && (r_hcnt < HS_END_C);
  assign w_vs     = (r_vcnt >= VS_BEG_C) && (r_vcnt < VS_END_C);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_div <= '0;
    else if (w_pix_en) r_div <= '0;
    else r_div <= r_div + DIV_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_pix_en) begin
      r_hcnt <= w_h_wrap ? '0 : r_hcnt + CNT_W'(1);
      if (w_h_wrap) r_vcnt <= w_v_wrap ? '0 : r_vcnt + CNT_W'(1);
    end
  end

  // Coordinate stage: hs/vs/video are registered here so everything downstream
  // is measured from the tick on which col/row appear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col         <= '0;
      r_row         <= '0;
      r_video       <= 1'b0;
      r_hs          <= 1'b0;
      r_vs          <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_en && (r_hcnt == '0) && (r_vcnt == '0);
      if (w_pix_en) begin
        r_col   <= r_hcnt;
        r_row   <= r_vcnt;
        r_video <= w_active;
        r_hs    <= w_hs;
        r_vs    <= w_vs;
      end
    end
  end

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DLY)
  ) u_dly (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_en    (w_pix_en),
    .i_d     ({r_hs, r_vs, r_video}),
    .o_q     (w_dly)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_out <= ~SYNC_POL;
      r_vs_out <= ~SYNC_POL;
      r_rgb    <= '0;
    end else if (w_pix_en) begin
      r_hs_out <= w_dly[2] ? SYNC_POL : ~SYNC_POL;
      r_vs_out <= w_dly[1] ? SYNC_POL : ~SYNC_POL;
      r_rgb    <= w_dly[0] ? {red_in, green_in, blue_in} : '0;
    end
  end

  assign col         = r_col;
  assign row         = r_row;
  assign video_on    = r_video;
  assign frame_start = r_frame_start;
  assign vga_hs      = r_hs_out;
  assign vga_vs      = r_vs_out;
  assign vga_r       = r_rgb.r;
  assign vga_g       = r_rgb.g;
  assign vga_b       = r_rgb.b;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: standard timing (div 2 / pipe 2), div 1 / pipe 3, and a tiny raster for frame-level checks.
module tb_vga_timing_gen;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int c = 0;

  always #10 clock = ~clock;

  // Instance A: default build
  logic [3:0] a_red;
  logic [9:0] a_col, a_row;
  logic a_video, a_fs, a_hs, a_vs;
  logic [3:0] a_r, a_g, a_b;
  logic a_tick;
  logic [9:0] a_pipe [2];

  vga_timing_gen u_a (
    .clock(clock), .reset_n(reset_n),
    .red_in(a_red), .green_in(4'hf), .blue_in(4'hf),
    .col(a_col), .row(a_row), .video_on(a_video), .frame_start(a_fs),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
  );

  // Renderer model: returns col[3:0] two pixel ticks later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_tick    <= 1'b0;
      a_pipe[0] <= '0;
      a_pipe[1] <= '0;
    end else begin
      a_tick <= ~a_tick;
      if (a_tick) begin
        a_pipe[0] <= a_col;
        a_pipe[1] <= a_pipe[0];
      end
    end
  end
  assign a_red = a_pipe[1][3:0];

  // Instance B: one clock per pixel, three-tick renderer latency
  logic [3:0] b_red;
  logic [9:0] b_col, b_row;
  logic b_video, b_fs, b_hs, b_vs;
  logic [3:0] b_r, b_g, b_b;
  logic [9:0] b_pipe [3];

  vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(3)) u_b (
    .clock(clock), .reset_n(reset_n),
    .red_in(b_red), .green_in(4'hf), .blue_in(4'hf),
    .col(b_col), .row(b_row), .video_on(b_video), .frame_start(b_fs),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_pipe[0] <= '0;
      b_pipe[1] <= '0;
      b_pipe[2] <= '0;
    end else begin
      b_pipe[0] <= b_col;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
    end
  end
  assign b_red = b_pipe[2][3:0];

  // Instance C: 16 x 9 raster (8x4 visible), hs at col 10..12, vs at rows 5..6
  logic [9:0] c_col, c_row;
  logic c_video, c_fs, c_hs, c_vs;
  logic [3:0] c_r, c_g, c_b;

  vga_timing_gen #(
    .CLK_DIV(1), .PIPE_DLY(1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_c (
    .clock(clock), .reset_n(reset_n),
    .red_in(4'hf), .green_in(4'hf), .blue_in(4'hf),
    .col(c_col), .row(c_row), .video_on(c_video), .frame_start(c_fs),
    .vga_hs(c_hs), .vga_vs(c_vs), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // c counts clock edges since reset release; sampling happens on the following falling edge
  task automatic goto(input int tgt);
    while (c < tgt) begin
      @(negedge clock);
      c++;
    end
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_col"}, int'(a_col), 0);
    chk({tag, "_row"}, int'(a_row), 0);
    chk({tag, "_video"}, int'(a_video), 0);
    chk({tag, "_fs"}, int'(a_fs), 0);
    chk({tag, "_hs"}, int'(a_hs), 1);
    chk({tag, "_vs"}, int'(a_vs), 1);
    chk({tag, "_rgb"}, int'({a_r, a_g, a_b}), 0);
  endtask

  initial begin
    int vcount;
    repeat (3) @(negedge clock);
    chk_a_reset("rst_a");
    chk("rst_b_hs", int'(b_hs), 1);
    chk("rst_c_vs", int'(c_vs), 1);
    reset_n = 1'b1;
    c = 0;

    goto(1);
    chk("a_fs_c1", int'(a_fs), 0);
    chk("b_fs_c1", int'(b_fs), 1);
    chk("c_fs_c1", int'(c_fs), 1);
    goto(2);
    chk("a_fs_c2", int'(a_fs), 1);
    chk("a_video_c2", int'(a_video), 1);
    goto(3);
    chk("a_fs_c3", int'(a_fs), 0);
    chk("c_g_px0", int'(c_g), 15);
    goto(10);
    chk("b_r_px5", int'(b_r), 5);
    chk("c_g_px7", int'(c_g), 15);
    goto(11);
    chk("c_g_px8_blank", int'(c_g), 0);
    goto(12);
    chk("c_hs_pre", int'(c_hs), 1);
    goto(13);
    chk("c_hs_fall", int'(c_hs), 0);
    goto(15);
    chk("c_hs_last", int'(c_hs), 0);
    goto(16);
    chk("c_hs_rise", int'(c_hs), 1);
    goto(17);
    chk("b_r_px12", int'(b_r), 12);
    goto(18);
    chk("a_r_px5", int'(a_r), 5);
    chk("a_g_px5", int'(a_g), 15);
    chk("a_b_px5", int'(a_b), 15);
    goto(22);
    chk("a_col_10", int'(a_col), 10);
    goto(28);
    chk("a_r_px10", int'(a_r), 10);
    goto(49);
    chk("c_video_row3", int'(c_video), 1);
    goto(51);
    chk("c_g_row3", int'(c_g), 15);
    goto(65);
    chk("c_video_row4", int'(c_video), 0);
    goto(67);
    chk("c_g_row4_blank", int'(c_g), 0);
    goto(82);
    chk("c_vs_pre", int'(c_vs), 1);
    goto(83);
    chk("c_vs_fall", int'(c_vs), 0);
    goto(114);
    chk("c_vs_last", int'(c_vs), 0);
    goto(115);
    chk("c_vs_rise", int'(c_vs), 1);
    goto(144);
    chk("c_col_end", int'(c_col), 15);
    chk("c_row_end", int'(c_row), 8);
    chk("c_fs_end", int'(c_fs), 0);
    goto(145);
    chk("c_col_wrap", int'(c_col), 0);
    chk("c_row_wrap", int'(c_row), 0);
    chk("c_fs_wrap", int'(c_fs), 1);
    goto(146);
    chk("c_fs_after", int'(c_fs), 0);
    vcount = 0;
    for (int i = 0; i < 144; i++) begin
      goto(c + 1);
      if (c_video) vcount++;
    end
    chk("c_video_per_frame", vcount, 32);

    goto(660);
    chk("b_hs_pre", int'(b_hs), 1);
    goto(661);
    chk("b_hs_fall", int'(b_hs), 0);
    goto(756);
    chk("b_hs_last", int'(b_hs), 0);
    goto(757);
    chk("b_hs_rise", int'(b_hs), 1);
    goto(1280);
    chk("a_video_639", int'(a_video), 1);
    goto(1282);
    chk("a_video_640", int'(a_video), 0);
    goto(1286);
    chk("a_r_px639", int'(a_r), 15);
    goto(1288);
    chk("a_r_px640_blank", int'(a_r), 0);
    chk("a_g_px640_blank", int'(a_g), 0);
    goto(1319);
    chk("a_hs_pre", int'(a_hs), 1);
    goto(1320);
    chk("a_hs_fall", int'(a_hs), 0);
    chk("a_vs_line0", int'(a_vs), 1);
    goto(1460);
    chk("b_hs_pre2", int'(b_hs), 1);
    goto(1461);
    chk("b_hs_fall2", int'(b_hs), 0);
    goto(1511);
    chk("a_hs_last", int'(a_hs), 0);
    goto(1512);
    chk("a_hs_rise", int'(a_hs), 1);
    goto(2919);
    chk("a_hs_pre2", int'(a_hs), 1);
    goto(2920);
    chk("a_hs_fall2", int'(a_hs), 0);
    goto(17600);
    chk("a_col_799", int'(a_col), 799);
    chk("a_row_10", int'(a_row), 10);
    goto(17602);
    chk("a_col_wrap", int'(a_col), 0);
    chk("a_row_11", int'(a_row), 11);
    chk("a_fs_linewrap", int'(a_fs), 0);
    goto(18202);
    chk("a_col_300", int'(a_col), 300);
    chk("a_g_mid", int'(a_g), 15);

    // Mid-frame reset must clear outputs without a clock edge
    #1 reset_n = 1'b0;
    #1 chk_a_reset("async_a");
    repeat (3) @(negedge clock);
    chk("held_a_col", int'(a_col), 0);
    chk("held_b_hs", int'(b_hs), 1);
    reset_n = 1'b1;
    c = 0;

    goto(1);
    chk("re_a_fs_c1", int'(a_fs), 0);
    goto(2);
    chk("re_a_fs_c2", int'(a_fs), 1);
    chk("re_a_col", int'(a_col), 0);
    goto(660);
    chk("re_b_hs_pre", int'(b_hs), 1);
    goto(661);
    chk("re_b_hs_fall", int'(b_hs), 0);
    goto(1319);
    chk("re_a_hs_pre", int'(a_hs), 1);
    goto(1320);
    chk("re_a_hs_fall", int'(a_hs), 0);
    goto(1512);
    chk("re_a_hs_rise", int'(a_hs), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
